imem_loader: RTL and testbench

Boot-time loader that fills the CPU's instruction memory from an external byte stream before execution starts. Accepts bytes over a valid/ready handshake, packs four bytes little-endian into one 32-bit instruction word, and issues one write per word to instruction memory at consecutive word-aligned addresses. Holds the CPU in reset (`cpu_hold`) until the requested number of words has been written, then releases it.

---
 rtl/imem_loader_if.sv | 34 +++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the byte-stream handshake and the instruction-memory write port
//   of the boot loader into one bundle.
//   Byte stream : byte_valid / byte_data (source -> loader), byte_ready (loader -> source)
//   Memory write: mem_we, mem_addr (byte address, word aligned), mem_wdata (loader -> memory)
//   Modports:
//     master - the environment side (byte source and memory sink)
//     slave  - the loader side
interface imem_loader_if;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader: packs a little-endian byte stream into 32-bit words and
//   writes them to instruction memory at consecutive word-aligned addresses,
//   holding the CPU in reset until the requested number of words is written.
//   Ports:
//     clk        - single clock, rising edge
//     reset      - asynchronous, active-high
//     start      - one-cycle load request
//     word_count - number of words to load (sampled on an accepted start)
//     bus        - byte handshake + memory write port (imem_loader_if.slave)
//     cpu_hold   - high keeps the CPU in reset
//     done       - load complete
//     error      - sticky protocol/range error
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    imem_loader_if.slave          bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Largest loadable count: the whole memory, 2^ADDR_WIDTH words.
    localparam logic [ADDR_WIDTH:0]   MAX_COUNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   ZERO_COUNT = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   ONE_COUNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX   = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH:0]   count_q,    count_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    // Only the first three lanes need storage; the fourth byte goes
    // straight into the write-data register when it is accepted.
    logic [23:0]           data_q,     data_d;
    logic [31:0]           addr_q,     addr_d;
    logic [31:0]           wdata_q,    wdata_d;
    logic                  error_q,    error_d;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= ZERO_COUNT;
            word_idx_q <= ZERO_IDX;
            byte_idx_q <= 2'd0;
            data_q     <= 24'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        data_d     = data_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;

        case (state_q)
            // DONE accepts a new start exactly like IDLE, allowing a reload.
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (word_count == ZERO_COUNT) begin
                        state_d = S_DONE;
                    end else if (word_count > MAX_COUNT) begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end else begin
                        count_d    = word_count;
                        word_idx_d = ZERO_IDX;
                        byte_idx_d = 2'd0;
                        error_d    = 1'b0;
                        state_d    = S_RECV;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            S_RECV: begin
                if (start) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                // byte_ready is high throughout RECV, so byte_valid alone
                // marks a completed handshake here.
                if (bus.byte_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: data_d[7:0]   = bus.byte_data;
                        2'd1: data_d[15:8]  = bus.byte_data;
                        2'd2: data_d[23:16] = bus.byte_data;
                        2'd3: begin
                            wdata_d = {bus.byte_data, data_q};
                            addr_d  = {{(30-ADDR_WIDTH){1'b0}}, word_idx_q, 2'b00};
                            state_d = S_WRITE;
                        end
                        default: byte_idx_d = 2'd0;
                    endcase
                end else begin
                    byte_idx_d = byte_idx_q;
                end
            end

            S_WRITE: begin
                if (start) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_q;
                end
                // Compare before incrementing so the index never wraps on a
                // full-memory load.
                if (({1'b0, word_idx_q} + ONE_COUNT) == count_q) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + ONE_IDX;
                    state_d    = S_RECV;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    assign bus.byte_ready = (state_q == S_RECV);
    assign bus.mem_we     = (state_q == S_WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign cpu_hold       = (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader (ADDR_WIDTH = 8). Inputs are driven 1 ns
//   after the rising edge and outputs are sampled at that same point; memory
//   writes are logged on the falling edge.
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] word_count;
    logic       cpu_hold;
    logic       done;
    logic       error;

    imem_loader_if bus_if ();

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus_if),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  stim    [0:1023];
    logic [31:0] wr_addr [0:511];
    logic [31:0] wr_data [0:511];
    int          wr_n = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write logger: one entry per cycle with mem_we high.
    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            if (wr_n < 512) begin
                wr_addr[wr_n] = bus_if.mem_addr;
                wr_data[wr_n] = bus_if.mem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [8:0] cnt);
        word_count = cnt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Streams stim[0..n_bytes-1] until done or budget; optionally toggles
    // byte_valid and pulses start once when pulse_idx bytes have been taken.
    task automatic run_load(input int n_bytes, input bit toggle, input int pulse_idx,
                            input int budget, output int cycles, output int ready_drops);
        int idx;
        bit pulsed;
        bit accept;
        idx = 0;
        pulsed = 1'b0;
        cycles = 0;
        ready_drops = 0;
        while ((done !== 1'b1) && (cycles < budget)) begin
            if (idx < n_bytes) begin
                bus_if.byte_valid = toggle ? ((cycles % 2) == 0) : 1'b1;
                bus_if.byte_data  = stim[idx];
            end else begin
                bus_if.byte_valid = 1'b0;
            end
            if (((idx % 4) != 0) && (idx < n_bytes) && (bus_if.byte_ready !== 1'b1)) begin
                ready_drops++;
            end
            start  = (idx == pulse_idx) && !pulsed;
            accept = (bus_if.byte_valid === 1'b1) && (bus_if.byte_ready === 1'b1);
            tick();
            if (start) pulsed = 1'b1;
            start = 1'b0;
            cycles++;
            if (accept) idx++;
        end
        bus_if.byte_valid = 1'b0;
        check("load_finished", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cycles;
        int drops;
        int base;
        int bad;
        logic [31:0] exp_w;

        reset = 1'b1;
        start = 1'b0;
        word_count = 9'd0;
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'd0;
        tick();
        tick();

        // Reset values.
        check("rst_byte_ready", {31'd0, bus_if.byte_ready}, 32'd0);
        check("rst_mem_we",     {31'd0, bus_if.mem_we},     32'd0);
        check("rst_mem_addr",   bus_if.mem_addr,            32'd0);
        check("rst_mem_wdata",  bus_if.mem_wdata,           32'd0);
        check("rst_cpu_hold",   {31'd0, cpu_hold},          32'd1);
        check("rst_done",       {31'd0, done},              32'd0);
        check("rst_error",      {31'd0, error},             32'd0);
        reset = 1'b0;
        tick();
        check("idle_ready_low", {31'd0, bus_if.byte_ready}, 32'd0);

        stim[0] = 8'h13; stim[1] = 8'h05; stim[2] = 8'hA0; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h05; stim[6] = 8'h50; stim[7] = 8'h00;

        // Two-word load, byte_valid held high.
        base = wr_n;
        do_start(9'd2);
        check("t1_ready_after_start", {31'd0, bus_if.byte_ready}, 32'd1);
        run_load(8, 1'b0, -1, 40, cycles, drops);
        check("t1_cycles", cycles, 32'd10);
        check("t1_wr_count", wr_n - base, 32'd2);
        check("t1_addr0", wr_addr[base],     32'h0000_0000);
        check("t1_data0", wr_data[base],     32'h00A0_0513);
        check("t1_addr1", wr_addr[base + 1], 32'h0000_0004);
        check("t1_data1", wr_data[base + 1], 32'h0050_0593);
        check("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("t1_hold_addr",  bus_if.mem_addr,  32'h0000_0004);
        check("t1_hold_wdata", bus_if.mem_wdata, 32'h0050_0593);

        // Same load with byte_valid toggling (reload from DONE).
        base = wr_n;
        do_start(9'd2);
        check("t2_hold_back", {31'd0, cpu_hold}, 32'd1);
        check("t2_done_low",  {31'd0, done},     32'd0);
        run_load(8, 1'b1, -1, 60, cycles, drops);
        check("t2_ready_drops", drops, 32'd0);
        check("t2_wr_count", wr_n - base, 32'd2);
        check("t2_addr0", wr_addr[base],     32'h0000_0000);
        check("t2_data0", wr_data[base],     32'h00A0_0513);
        check("t2_addr1", wr_addr[base + 1], 32'h0000_0004);
        check("t2_data1", wr_data[base + 1], 32'h0050_0593);

        // Zero count, then out-of-range count, both from IDLE.
        pulse_reset();
        base = wr_n;
        do_start(9'd0);
        check("t3_zero_done", {31'd0, done},     32'd1);
        check("t3_zero_hold", {31'd0, cpu_hold}, 32'd0);
        tick();
        check("t3_zero_no_write", wr_n - base, 32'd0);
        pulse_reset();
        do_start(9'd257);
        check("t3_range_error", {31'd0, error},             32'd1);
        check("t3_range_hold",  {31'd0, cpu_hold},          32'd1);
        check("t3_range_done",  {31'd0, done},              32'd0);
        check("t3_range_ready", {31'd0, bus_if.byte_ready}, 32'd0);
        tick();
        check("t3_range_sticky", {31'd0, error}, 32'd1);

        // Valid start clears error; start mid-load sets it but load completes.
        base = wr_n;
        do_start(9'd2);
        check("t4_error_cleared", {31'd0, error}, 32'd0);
        run_load(8, 1'b0, 2, 40, cycles, drops);
        check("t4_error_set", {31'd0, error}, 32'd1);
        check("t4_cycles", cycles, 32'd10);
        check("t4_wr_count", wr_n - base, 32'd2);
        check("t4_addr1", wr_addr[base + 1], 32'h0000_0004);
        check("t4_data0", wr_data[base],     32'h00A0_0513);
        check("t4_data1", wr_data[base + 1], 32'h0050_0593);

        // Reset after three bytes of word 1.
        base = wr_n;
        do_start(9'd2);
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = 8'hAA; tick();
        bus_if.byte_data  = 8'hBB; tick();
        bus_if.byte_data  = 8'hCC; tick();
        bus_if.byte_valid = 1'b0;
        reset = 1'b1;
        #2;
        check("t5_rst_ready", {31'd0, bus_if.byte_ready}, 32'd0);
        check("t5_rst_we",    {31'd0, bus_if.mem_we},     32'd0);
        check("t5_rst_addr",  bus_if.mem_addr,            32'd0);
        check("t5_rst_wdata", bus_if.mem_wdata,           32'd0);
        check("t5_rst_hold",  {31'd0, cpu_hold},          32'd1);
        check("t5_rst_error", {31'd0, error},             32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("t5_no_write", wr_n - base, 32'd0);
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        do_start(9'd1);
        run_load(4, 1'b0, -1, 20, cycles, drops);
        check("t5_wr_count", wr_n - base, 32'd1);
        check("t5_addr", wr_addr[base], 32'h0000_0000);
        check("t5_data", wr_data[base], 32'h4433_2211);

        // Full-memory load with incrementing bytes.
        for (int i = 0; i < 1024; i++) stim[i] = 8'(i);
        base = wr_n;
        do_start(9'd256);
        run_load(1024, 1'b0, -1, 1400, cycles, drops);
        check("t6_cycles", cycles, 32'd1280);
        check("t6_wr_count", wr_n - base, 32'd256);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            if ((base + k) < 512) begin
                if ((wr_addr[base + k] !== 32'(k*4)) || (wr_data[base + k] !== exp_w)) bad++;
            end else begin
                bad++;
            end
        end
        check("t6_bad_words", bad, 32'd0);
        check("t6_last_addr", wr_addr[base + 255], 32'h0000_03FC);
        check("t6_last_data", wr_data[base + 255], 32'hFFFE_FDFC);
        check("t6_done_hold", {31'd0, cpu_hold}, 32'd0);
        check("t6_hold_addr", bus_if.mem_addr, 32'h0000_03FC);
        tick();
        check("t6_no_extra_write", wr_n - base, 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
